alu_share_ctrl: RTL and testbench

- Round-robin controller that shares one combinational ALU (module ALU: 32-bit A/B, 5-bit controls, 3-bit flags {carry,zero,sign}) between N_REQ requesters.
- Each requester submits operands plus a control word over a valid/ready handshake. The controller registers the operands, drives the ALU, captures result and flags, and returns them over a per-requester response handshake.
- It sits between issue logic and the ALU instance. The ALU itself is instantiated outside this block.

---
 rtl/alu_share_ctrl_pkg.sv | 20 ++
 rtl/alu.sv | 49 ++++
 rtl/alu_share_ctrl_rr_arbiter.sv | 33 +++
 rtl/alu_share_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// rtl/alu_share_ctrl_pkg.sv - shared state encoding, flag indices and ALU control constants
package alu_share_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CARRY = 2;
    localparam int ZERO  = 1;
    localparam int SIGN  = 0;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] AND  = 5'b00001;
    localparam logic [4:0] XOR  = 5'b00010;
    localparam logic [4:0] SHL  = 5'b00011;
    localparam logic [4:0] DIFF = 5'b10000;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU shared by the requesters of alu_share_ctrl
module alu
    import alu_share_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [4:0]   ctrl,
    output logic [W-1:0] result_final,
    output logic [2:0]   flags
);

    logic [W:0]   sum;
    logic [W-1:0] diff_bits;
    logic         carry;

    always_comb begin
        sum          = '0;
        diff_bits    = '0;
        carry        = 1'b0;
        result_final = '0;
        case (ctrl)
            ADD: begin
                sum          = {1'b0, a} + {1'b0, b};
                result_final = sum[W-1:0];
                carry        = sum[W];
            end
            AND: result_final = a & b;
            XOR: result_final = a ^ b;
            SHL: result_final = a << b[4:0];
            DIFF: begin
                // index of the most significant bit where a and b differ
                diff_bits = a ^ b;
                for (int i = 0; i < W; i++) begin
                    if (diff_bits[i]) begin
                        result_final = W'(i);
                    end
                end
            end
            default: result_final = '0;
        endcase
        flags        = '0;
        flags[CARRY] = carry;
        flags[ZERO]  = (result_final == '0);
        flags[SIGN]  = result_final[W-1];
    end

endmodule

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rtl/alu_share_ctrl_rr_arbiter.sv - round-robin pick of the first valid requester at or after ptr
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one combinational ALU between N_REQ requesters in round-robin order
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*CTRL_W-1:0] req_ctrl,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_result,
    output logic [2:0]              rsp_flags,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [CTRL_W-1:0]       alu_ctrl,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic [2:0]              alu_flags,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [2:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    a_d       = req_a[int'(grant_idx)*DATA_W +: DATA_W];
                    b_d       = req_b[int'(grant_idx)*DATA_W +: DATA_W];
                    ctrl_d    = req_ctrl[int'(grant_idx)*CTRL_W +: CTRL_W];
                    owner_d   = grant_idx;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                flags_d  = alu_flags;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    // next search starts just past the requester that was served
                    if (int'(owner_q) == N_REQ - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = owner_q + IDX_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed bench for alu_share_ctrl driving a real ALU
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 5;
    localparam int CNT_W  = 16;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ*CTRL_W-1:0] req_ctrl;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]       rsp_result;
    logic [2:0]              rsp_flags;
    logic [DATA_W-1:0]       alu_a;
    logic [DATA_W-1:0]       alu_b;
    logic [CTRL_W-1:0]       alu_ctrl;
    logic [DATA_W-1:0]       alu_result;
    logic [2:0]              alu_flags;
    logic                    busy;
    logic [CNT_W-1:0]        op_count;

    int total;
    int bad;

    alu_share_ctrl #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .busy       (busy),
        .op_count   (op_count)
    );

    alu #(.W(DATA_W)) u_alu (
        .a            (alu_a),
        .b            (alu_b),
        .ctrl         (alu_ctrl),
        .result_final (alu_result),
        .flags        (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] c);
        req_a[i*DATA_W +: DATA_W]    = a;
        req_b[i*DATA_W +: DATA_W]    = b;
        req_ctrl[i*CTRL_W +: CTRL_W] = c;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        req_ctrl = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        total++; if ({alu_a, alu_b, alu_ctrl} !== '0) begin bad++; $display("FAIL reset_alu_drive got=%h/%h/%h exp=0", alu_a, alu_b, alu_ctrl); end
        total++; if ({rsp_result, rsp_flags} !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h/%b exp=0", rsp_result, rsp_flags); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        @(negedge clk);
        set_req(0, 32'd5, 32'd7, ADD);
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL add_req_ready got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        total++; if (busy !== 1'b1 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin bad++; $display("FAIL add_exec got busy=%b rsp_valid=%b req_ready=%b exp 1/00/00", busy, rsp_valid, req_ready); end
        total++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== ADD) begin bad++; $display("FAIL add_alu_drive got=%h/%h/%h exp=5/7/00", alu_a, alu_b, alu_ctrl); end
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL add_rsp_valid got=%b exp=01", rsp_valid); end
        total++; if (rsp_result !== 32'd12 || rsp_flags !== 3'b000) begin bad++; $display("FAIL add_result got=%0d/%b exp=12/000", rsp_result, rsp_flags); end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        total++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL add_done got rsp_valid=%b busy=%b exp 00/0", rsp_valid, busy); end
        total++; if (op_count !== 16'd1) begin bad++; $display("FAIL add_op_count got=%0d exp=1", op_count); end
    endtask

    task automatic test_carry_zero;
        @(negedge clk);
        set_req(1, 32'hFFFF_FFFF, 32'd1, ADD);
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL carry_req_ready got=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL carry_rsp_valid got=%b exp=10", rsp_valid); end
        total++; if (rsp_result !== 32'd0 || rsp_flags !== 3'b110) begin bad++; $display("FAIL carry_result got=%h/%b exp=0/110", rsp_result, rsp_flags); end
        rsp_ready = 2'b11;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        total++; if (op_count !== 16'd2 || busy !== 1'b0) begin bad++; $display("FAIL carry_done got op_count=%0d busy=%b exp 2/0", op_count, busy); end
    endtask

    task automatic test_contention;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rsp;
        @(negedge clk);
        set_req(0, 32'h0000_F0F0, 32'h0000_F0F0, XOR);
        set_req(1, 32'h0000_F0F0, 32'h0000_F0F0, XOR);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int t = 0; t < 12; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            exp_rdy = 2'b00;
            exp_rsp = 2'b00;
            if (t % 3 == 0) exp_rdy = ((t / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (t % 3 == 2) exp_rsp = ((t / 3) % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL contention_grant t=%0d got=%b exp=%b", t, req_ready, exp_rdy); end
            total++; if (rsp_valid !== exp_rsp) begin bad++; $display("FAIL contention_rsp t=%0d got=%b exp=%b", t, rsp_valid, exp_rsp); end
            if (t % 3 == 2) begin
                total++; if (rsp_result !== 32'd0 || rsp_flags !== 3'b010) begin bad++; $display("FAIL contention_result t=%0d got=%h/%b exp=0/010", t, rsp_result, rsp_flags); end
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        total++; if (op_count !== 16'd6 || busy !== 1'b0) begin bad++; $display("FAIL contention_done got op_count=%0d busy=%b exp 6/0", op_count, busy); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        set_req(1, 32'h0000_F0F0, 32'h0000_0F0F, XOR);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_req_ready got=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_exec_ready got=%b exp=00", req_ready); end
        @(negedge clk);
        rsp_ready = 2'b01;
        #1;
        total++; if (rsp_valid !== 2'b10 || rsp_result !== 32'h0000_FFFF) begin bad++; $display("FAIL bp_first_rsp got=%b/%h exp=10/0000ffff", rsp_valid, rsp_result); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (rsp_valid !== 2'b10 || rsp_result !== 32'h0000_FFFF || rsp_flags !== 3'b000 || req_ready !== 2'b00 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold c=%0d got valid=%b result=%h flags=%b ready=%b busy=%b exp 10/0000ffff/000/00/1",
                         c, rsp_valid, rsp_result, rsp_flags, req_ready, busy);
            end
        end
        @(negedge clk);
        rsp_ready = 2'b10;
        req_valid = 2'b00;
        #1;
        total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL bp_before_release got=%b exp=10", rsp_valid); end
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        total++; if (rsp_valid !== 2'b00 || op_count !== 16'd7) begin bad++; $display("FAIL bp_release got valid=%b op_count=%0d exp 00/7", rsp_valid, op_count); end
    endtask

    task automatic test_diff;
        @(negedge clk);
        set_req(0, 32'h8, 32'h0, DIFF);
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL diff_req_ready got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd3 || rsp_flags !== 3'b000) begin bad++; $display("FAIL diff_result got=%b/%0d/%b exp=01/3/000", rsp_valid, rsp_result, rsp_flags); end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        total++; if (op_count !== 16'd8) begin bad++; $display("FAIL diff_op_count got=%0d exp=8", op_count); end
    endtask

    task automatic test_reset_exec;
        @(negedge clk);
        set_req(1, 32'd1, 32'd2, ADD);
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rst_exec_grant got=%b exp=10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_exec_busy got=%b exp=1", busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_exec_state got busy=%b rsp_valid=%b exp 0/00", busy, rsp_valid); end
        total++; if (op_count !== 16'd0 || rsp_result !== 32'd0 || alu_a !== 32'd0) begin bad++; $display("FAIL rst_exec_regs got op_count=%0d result=%h alu_a=%h exp 0/0/0", op_count, rsp_result, alu_a); end
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_exec_no_rsp got=%b exp=00", rsp_valid); end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_exec_next_grant got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_add;
        test_carry_zero;
        test_contention;
        test_backpressure;
        test_diff;
        test_reset_exec;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
